// File: rtl/ads4246_capture_ctrl.sv
// Capture sequencer for the ADS4246 front end: arm/trigger, decimate, pack A/B samples and
// hand them to the stream master through a single-entry valid/ready output register.
module ads4246_capture_ctrl #(
    parameter int unsigned SAMPLE_W = 14,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DECIM_W  = 8
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic [CNT_W-1:0]    cfg_frame_len,
    input  logic [CNT_W-1:0]    cfg_num_frames,
    input  logic [DECIM_W-1:0]  cfg_decim,
    input  logic                cfg_trig_en,
    input  logic                trig_in,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_cha,
    input  logic [SAMPLE_W-1:0] adc_chb,
    output logic [31:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [CNT_W-1:0]    frame_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture,
        StDrain
    } state_e;

    state_e               state_q, state_d;

    logic [CNT_W-1:0]     frame_len_q, frame_len_d;
    logic [CNT_W-1:0]     num_frames_q, num_frames_d;
    logic [DECIM_W-1:0]   decim_q, decim_d;
    logic                 trig_en_q, trig_en_d;

    logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
    logic [DECIM_W-1:0]   decim_cnt_q, decim_cnt_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                 trig_prev_q;

    logic [31:0]          out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 overflow_q, overflow_d;
    logic                 done_q, done_d;

    logic                 trig_edge;
    logic                 adc_take;
    logic                 kept;
    logic                 slot_free;
    logic                 load;
    logic                 drop;
    logic                 last_sample;

    function automatic logic [15:0] sext16(input logic [SAMPLE_W-1:0] s);
        logic [15:0] r;
        r = {16{s[SAMPLE_W-1]}};
        r[SAMPLE_W-1:0] = s;
        return r;
    endfunction

    always_comb begin
        trig_edge   = trig_in & ~trig_prev_q;
        adc_take    = adc_valid & (state_q == StCapture);
        kept        = adc_take & (decim_cnt_q == '0);
        slot_free   = ~out_valid_q | out_ready;
        load        = kept & slot_free;
        drop        = kept & ~slot_free;
        last_sample = (sample_cnt_q == frame_len_q - CNT_W'(1));
    end

    always_comb begin
        state_d      = state_q;
        frame_len_d  = frame_len_q;
        num_frames_d = num_frames_q;
        decim_d      = decim_q;
        trig_en_d    = trig_en_q;
        sample_cnt_d = sample_cnt_q;
        decim_cnt_d  = decim_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        overflow_d   = overflow_q;
        done_d       = 1'b0;

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = {sext16(adc_chb), sext16(adc_cha)};
            out_last_d  = last_sample;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A dropped sample leaves sample_cnt untouched so every frame still delivers
        // frame_len beats.
        if (drop) begin
            overflow_d = 1'b1;
        end

        if (adc_take) begin
            decim_cnt_d = (decim_cnt_q == decim_q) ? '0 : decim_cnt_q + DECIM_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (cfg_start && (cfg_frame_len != '0)) begin
                    frame_len_d  = cfg_frame_len;
                    num_frames_d = cfg_num_frames;
                    decim_d      = cfg_decim;
                    trig_en_d    = cfg_trig_en;
                    sample_cnt_d = '0;
                    decim_cnt_d  = '0;
                    frame_cnt_d  = '0;
                    overflow_d   = 1'b0;
                    state_d      = cfg_trig_en ? StArmed : StCapture;
                end
            end
            StArmed: begin
                if (trig_edge) begin
                    decim_cnt_d = '0;
                    state_d     = StCapture;
                end
            end
            StCapture: begin
                if (load) begin
                    if (last_sample) begin
                        sample_cnt_d = '0;
                        frame_cnt_d  = frame_cnt_q + CNT_W'(1);
                        if ((num_frames_q != '0) && (frame_cnt_d == num_frames_q)) begin
                            state_d = StDrain;
                        end else if (trig_en_q) begin
                            state_d = StArmed;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end
                end
            end
            StDrain: begin
                if (!out_valid_q || out_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (cfg_abort) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
            frame_cnt_d = frame_cnt_q;
            overflow_d  = overflow_q;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= StIdle;
            frame_len_q  <= '0;
            num_frames_q <= '0;
            decim_q      <= '0;
            trig_en_q    <= 1'b0;
            sample_cnt_q <= '0;
            decim_cnt_q  <= '0;
            frame_cnt_q  <= '0;
            trig_prev_q  <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_len_q  <= frame_len_d;
            num_frames_q <= num_frames_d;
            decim_q      <= decim_d;
            trig_en_q    <= trig_en_d;
            sample_cnt_q <= sample_cnt_d;
            decim_cnt_q  <= decim_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            trig_prev_q  <= trig_in;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ads4246_capture_ctrl.sv
// Self-checking bench for ads4246_capture_ctrl: directed scenarios plus randomized runs
// compared against a sample-list reference model.
module tb_ads4246_capture_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cfg_start, cfg_abort, cfg_trig_en, trig_in, adc_valid, out_ready;
    logic [15:0] cfg_frame_len, cfg_num_frames;
    logic [7:0]  cfg_decim;
    logic [13:0] adc_cha, adc_chb;
    logic [31:0] out_data;
    logic        out_valid, out_last, busy, done, overflow;
    logic [15:0] frame_cnt;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    logic [31:0] beat_data[$];
    logic        beat_last[$];
    int          beat_cyc[$];
    int          done_cyc[$];
    logic [13:0] sa[$];
    logic [13:0] sb[$];
    logic [31:0] exp_d[$];
    logic        exp_l[$];

    ads4246_capture_ctrl dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .cfg_frame_len  (cfg_frame_len),
        .cfg_num_frames (cfg_num_frames),
        .cfg_decim      (cfg_decim),
        .cfg_trig_en    (cfg_trig_en),
        .trig_in        (trig_in),
        .adc_valid      (adc_valid),
        .adc_cha        (adc_cha),
        .adc_chb        (adc_chb),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .frame_cnt      (frame_cnt)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Handshakes and done pulses observed mid-cycle, away from the active edge.
    always @(negedge ACLK) begin
        if (!ARESET && out_valid && out_ready) begin
            beat_data.push_back(out_data);
            beat_last.push_back(out_last);
            beat_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] pack(input logic [13:0] a, input logic [13:0] b);
        return {{2{b[13]}}, b, {2{a[13]}}, a};
    endfunction

    // Kept samples are every (dec+1)-th one counted from the start; the run ends after fl*nf.
    function automatic void model_run(input int fl, input int nf, input int dec);
        int kept = 0;
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < sa.size(); i++) begin
            if ((i % (dec + 1)) == 0 && kept < fl * nf) begin
                exp_d.push_back(pack(sa[i], sb[i]));
                exp_l.push_back((kept % fl) == fl - 1);
                kept++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mon();
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
        done_cyc.delete();
        sa.delete();
        sb.delete();
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_frame_len = '0;
        cfg_num_frames = '0;
        cfg_decim = '0;
        cfg_trig_en = 1'b0;
        trig_in = 1'b0;
        adc_valid = 1'b0;
        adc_cha = '0;
        adc_chb = '0;
        out_ready = 1'b1;
        tick_n(2);
        ARESET = 1'b0;
    endtask

    task automatic start_run(input int fl, input int nf, input int dec, input logic trig);
        cfg_frame_len = 16'(fl);
        cfg_num_frames = 16'(nf);
        cfg_decim = 8'(dec);
        cfg_trig_en = trig;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({out_valid, out_last, busy, done, overflow} !== 5'b0) begin
            failed++;
            $display("FAIL reset_flags: {valid,last,busy,done,ovf}=%b required 00000",
                     {out_valid, out_last, busy, done, overflow});
        end
        tests++;
        if (out_data !== 32'h0) begin
            failed++;
            $display("FAIL reset_data: out_data=%h required 00000000", out_data);
        end
        tests++;
        if (frame_cnt !== 16'h0) begin
            failed++;
            $display("FAIL reset_frame_cnt: frame_cnt=%0d required 0", frame_cnt);
        end
    endtask

    task automatic test_basic();
        clear_mon();
        out_ready = 1'b1;
        start_run(4, 2, 0, 1'b0);
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL basic_busy: busy=%b required 1", busy);
        end
        for (int i = 0; i < 16; i++) begin
            adc_valid = (i % 2 == 0);
            adc_cha = 14'h1FFF;
            adc_chb = 14'h2000;
            tick();
        end
        adc_valid = 1'b0;
        wait_idle(20, "basic");
        tick_n(2);
        tests++;
        if (beat_data.size() !== 8) begin
            failed++;
            $display("FAIL basic_count: beats=%0d required 8", beat_data.size());
        end
        for (int i = 0; i < beat_data.size() && i < 8; i++) begin
            tests++;
            if ({beat_last[i], beat_data[i]} !== {(i % 4 == 3), 32'hE000_1FFF}) begin
                failed++;
                $display("FAIL basic_beat%0d: last=%b data=%h required last=%b data=e0001fff",
                         i, beat_last[i], beat_data[i], (i % 4 == 3));
            end
        end
        tests++;
        if (frame_cnt !== 16'd2) begin
            failed++;
            $display("FAIL basic_frame_cnt: frame_cnt=%0d required 2", frame_cnt);
        end
        tests++;
        if (done_cyc.size() !== 1) begin
            failed++;
            $display("FAIL basic_done_count: pulses=%0d required 1", done_cyc.size());
        end else if (beat_cyc.size() == 8) begin
            tests++;
            if (done_cyc[0] !== beat_cyc[7] + 1) begin
                failed++;
                $display("FAIL basic_done_timing: done at %0d required %0d",
                         done_cyc[0], beat_cyc[7] + 1);
            end
        end
    endtask

    task automatic test_decim();
        clear_mon();
        start_run(3, 1, 2, 1'b0);
        for (int i = 0; i < 9; i++) begin
            adc_valid = 1'b1;
            adc_cha = 14'(i * 100 + 1);
            adc_chb = 14'(14'h3000 - 14'(i));
            sa.push_back(adc_cha);
            sb.push_back(adc_chb);
            tick();
        end
        adc_valid = 1'b0;
        wait_idle(20, "decim");
        tick_n(2);
        model_run(3, 1, 2);
        tests++;
        if (beat_data.size() !== exp_d.size()) begin
            failed++;
            $display("FAIL decim_count: beats=%0d required %0d", beat_data.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < beat_data.size(); i++) begin
            tests++;
            if ({beat_last[i], beat_data[i]} !== {exp_l[i], exp_d[i]}) begin
                failed++;
                $display("FAIL decim_beat%0d: last=%b data=%h required last=%b data=%h",
                         i, beat_last[i], beat_data[i], exp_l[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        out_ready = 1'b1;
        start_run(8, 1, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            adc_valid = 1'b1;
            adc_cha = 14'($urandom);
            adc_chb = 14'($urandom);
            sa.push_back(adc_cha);
            sb.push_back(adc_chb);
            tick();
        end
        adc_valid = 1'b0;
        wait_idle(20, "b2b");
        tick_n(2);
        model_run(8, 1, 0);
        tests++;
        if (beat_data.size() !== 8) begin
            failed++;
            $display("FAIL b2b_count: beats=%0d required 8", beat_data.size());
        end
        for (int i = 0; i < beat_data.size() && i < 8; i++) begin
            tests++;
            if ({beat_last[i], beat_data[i], beat_cyc[i]} !==
                {exp_l[i], exp_d[i], beat_cyc[0] + i}) begin
                failed++;
                $display("FAIL b2b_beat%0d: last=%b data=%h cyc=%0d required last=%b data=%h cyc=%0d",
                         i, beat_last[i], beat_data[i], beat_cyc[i], exp_l[i], exp_d[i],
                         beat_cyc[0] + i);
            end
        end
    endtask

    task automatic test_random();
        for (int run = 0; run < 6; run++) begin
            int fl, nf, dec, n;
            fl = $urandom_range(1, 6);
            nf = $urandom_range(1, 3);
            dec = $urandom_range(0, 3);
            clear_mon();
            out_ready = 1'b1;
            start_run(fl, nf, dec, 1'b0);
            n = 0;
            while (busy === 1'b1 && n < 400) begin
                adc_valid = 1'($urandom % 2);
                if (adc_valid) begin
                    adc_cha = 14'($urandom);
                    adc_chb = 14'($urandom);
                    sa.push_back(adc_cha);
                    sb.push_back(adc_chb);
                end
                tick();
                n++;
            end
            adc_valid = 1'b0;
            wait_idle(20, "random");
            tick_n(2);
            model_run(fl, nf, dec);
            tests++;
            if (beat_data.size() !== exp_d.size()) begin
                failed++;
                $display("FAIL random%0d_count: beats=%0d required %0d (fl=%0d nf=%0d dec=%0d)",
                         run, beat_data.size(), exp_d.size(), fl, nf, dec);
            end
            for (int i = 0; i < exp_d.size() && i < beat_data.size(); i++) begin
                tests++;
                if ({beat_last[i], beat_data[i]} !== {exp_l[i], exp_d[i]}) begin
                    failed++;
                    $display("FAIL random%0d_beat%0d: last=%b data=%h required last=%b data=%h",
                             run, i, beat_last[i], beat_data[i], exp_l[i], exp_d[i]);
                end
            end
            tests++;
            if ({frame_cnt, 32'(done_cyc.size())} !== {16'(nf), 32'd1}) begin
                failed++;
                $display("FAIL random%0d_end: frame_cnt=%0d done_pulses=%0d required %0d and 1",
                         run, frame_cnt, done_cyc.size(), nf);
            end
        end
    endtask

    task automatic test_trigger();
        clear_mon();
        exp_d.delete();
        exp_l.delete();
        out_ready = 1'b1;
        trig_in = 1'b0;
        start_run(2, 2, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            adc_valid = 1'b1;
            adc_cha = 14'($urandom);
            adc_chb = 14'($urandom);
            tick();
        end
        adc_valid = 1'b0;
        tick();
        tests++;
        if ({busy, beat_data.size() == 0} !== 2'b11) begin
            failed++;
            $display("FAIL trig_pre: busy=%b beats=%0d required busy=1 beats=0",
                     busy, beat_data.size());
        end
        for (int f = 0; f < 2; f++) begin
            trig_in = 1'b0;
            tick();
            // Sample alongside the edge is still seen in ARMED and must be ignored.
            trig_in = 1'b1;
            adc_valid = 1'b1;
            adc_cha = 14'h0AAA;
            adc_chb = 14'h1555;
            tick();
            for (int i = 0; i < 2; i++) begin
                adc_cha = 14'($urandom);
                adc_chb = 14'($urandom);
                exp_d.push_back(pack(adc_cha, adc_chb));
                exp_l.push_back(i == 1);
                tick();
            end
            if (f == 0) begin
                for (int i = 0; i < 4; i++) begin
                    adc_cha = 14'($urandom);
                    adc_chb = 14'($urandom);
                    tick();
                end
                adc_valid = 1'b0;
                tick();
                tests++;
                if ({frame_cnt, 32'(beat_data.size())} !== {16'd1, 32'd2}) begin
                    failed++;
                    $display("FAIL trig_held_high: frame_cnt=%0d beats=%0d required 1 and 2",
                             frame_cnt, beat_data.size());
                end
            end
            adc_valid = 1'b0;
        end
        trig_in = 1'b0;
        wait_idle(20, "trig");
        tick_n(2);
        tests++;
        if (beat_data.size() !== 4) begin
            failed++;
            $display("FAIL trig_count: beats=%0d required 4", beat_data.size());
        end
        for (int i = 0; i < 4 && i < beat_data.size(); i++) begin
            tests++;
            if ({beat_last[i], beat_data[i]} !== {exp_l[i], exp_d[i]}) begin
                failed++;
                $display("FAIL trig_beat%0d: last=%b data=%h required last=%b data=%h",
                         i, beat_last[i], beat_data[i], exp_l[i], exp_d[i]);
            end
        end
        tests++;
        if (done_cyc.size() !== 1) begin
            failed++;
            $display("FAIL trig_done: pulses=%0d required 1", done_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s[6];
        clear_mon();
        start_run(4, 1, 0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            adc_cha = 14'($urandom);
            adc_chb = 14'($urandom);
            s[i] = pack(adc_cha, adc_chb);
            adc_valid = 1'b1;
            tick();
            if (i == 2) begin
                adc_valid = 1'b0;
                tick();
                tests++;
                if ({overflow, out_valid, out_data} !== {2'b11, s[0]}) begin
                    failed++;
                    $display("FAIL bp_hold: ovf=%b valid=%b data=%h required 1 1 %h",
                             overflow, out_valid, out_data, s[0]);
                end
                out_ready = 1'b1;
                tick();
            end
        end
        adc_valid = 1'b0;
        wait_idle(20, "bp");
        tick_n(2);
        tests++;
        if (beat_data.size() !== 4) begin
            failed++;
            $display("FAIL bp_count: beats=%0d required 4", beat_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if ({beat_last[i], beat_data[i]} !== {(i == 3), (i == 0) ? s[0] : s[i + 2]}) begin
                    failed++;
                    $display("FAIL bp_beat%0d: last=%b data=%h required last=%b data=%h",
                             i, beat_last[i], beat_data[i], (i == 3),
                             (i == 0) ? s[0] : s[i + 2]);
                end
            end
        end
        tests++;
        if ({overflow, frame_cnt, 32'(done_cyc.size())} !== {1'b1, 16'd1, 32'd1}) begin
            failed++;
            $display("FAIL bp_end: ovf=%b frame_cnt=%0d done_pulses=%0d required 1 1 1",
                     overflow, frame_cnt, done_cyc.size());
        end
    endtask

    task automatic test_abort();
        clear_mon();
        start_run(4, 0, 0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            adc_valid = 1'b1;
            adc_cha = 14'($urandom);
            adc_chb = 14'($urandom);
            tick();
        end
        adc_valid = 1'b0;
        tests++;
        if ({busy, out_valid, overflow} !== 3'b111) begin
            failed++;
            $display("FAIL abort_pre: busy=%b valid=%b ovf=%b required 111",
                     busy, out_valid, overflow);
        end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        tests++;
        if ({busy, out_valid, overflow} !== 3'b001) begin
            failed++;
            $display("FAIL abort_post: busy=%b valid=%b ovf=%b required 001",
                     busy, out_valid, overflow);
        end
        tick_n(3);
        tests++;
        if (done_cyc.size() !== 0) begin
            failed++;
            $display("FAIL abort_no_done: pulses=%0d required 0", done_cyc.size());
        end
        cfg_frame_len = 16'd4;
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        tests++;
        if ({busy, overflow} !== 2'b01) begin
            failed++;
            $display("FAIL abort_wins: busy=%b ovf=%b required busy=0 ovf=1", busy, overflow);
        end
        out_ready = 1'b1;
        start_run(4, 0, 0, 1'b0);
        tests++;
        if ({busy, overflow} !== 2'b10) begin
            failed++;
            $display("FAIL abort_restart: busy=%b ovf=%b required busy=1 ovf=0", busy, overflow);
        end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        out_ready = 1'b1;
        start_run(2, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            adc_valid = 1'b1;
            adc_cha = 14'($urandom);
            adc_chb = 14'($urandom);
            if (i == 3) out_ready = 1'b0;
            tick();
        end
        adc_valid = 1'b0;
        tests++;
        if ({frame_cnt, overflow, out_valid} !== {16'd1, 2'b11}) begin
            failed++;
            $display("FAIL rst_mid_pre: frame_cnt=%0d ovf=%b valid=%b required 1 1 1",
                     frame_cnt, overflow, out_valid);
        end
        ARESET = 1'b1;
        tick();
        tests++;
        if ({out_valid, out_last, busy, done, overflow, out_data, frame_cnt} !== 53'h0) begin
            failed++;
            $display("FAIL rst_mid: valid=%b last=%b busy=%b done=%b ovf=%b data=%h frame_cnt=%0d required all 0",
                     out_valid, out_last, busy, done, overflow, out_data, frame_cnt);
        end
        ARESET = 1'b0;
        out_ready = 1'b1;
        tick();
        cfg_frame_len = 16'd0;
        cfg_num_frames = 16'd1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        tests++;
        if ({busy, out_valid} !== 2'b00) begin
            failed++;
            $display("FAIL zero_len_start: busy=%b valid=%b required 00", busy, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decim();
        test_back_to_back();
        test_random();
        test_trigger();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ads4246_capture_ctrl.md
# ads4246_capture_ctrl

Capture sequencer between the ADS4246 dual-channel ADC front end and the `axi_ads4246_v1_0_M_AXIS` stream master. It arms on a software start, optionally waits for an external trigger, decimates and packs A/B samples into 32-bit words, and presents them through a valid/ready handshake with per-frame last marking. It counts samples and frames, stops after a programmed number of frames, and flags samples lost to downstream backpressure.

## Interface
- `SAMPLE_W`, 14, ADC sample width per channel (≤16).
- `CNT_W`, 16, width of sample and frame counters and their config inputs.
- `DECIM_W`, 8, width of the decimation config.

- `ACLK`  in  1  single clock for all logic.
- `ARESET`  in  1  reset; synchronous, active-high.
- `cfg_start`  in  1  one-cycle start pulse; honoured only in IDLE.
- `cfg_abort`  in  1  return to IDLE from any state.
- `cfg_frame_len`  in  CNT_W  samples per frame; 0 makes `cfg_start` ignored.
- `cfg_num_frames`  in  CNT_W  frames per run; 0 = continuous until abort.
- `cfg_decim`  in  DECIM_W  keep 1 of every `cfg_decim`+1 ADC samples.
- `cfg_trig_en`  in  1  1 = each frame waits for a `trig_in` rising edge.
- `trig_in`  in  1  external trigger, synchronous to ACLK.
- `adc_valid`  in  1  one-cycle strobe: `adc_cha`/`adc_chb` hold a new sample.
- `adc_cha`, `adc_chb`  in  SAMPLE_W  two's-complement samples.
- `out_data`  out  32  `{sext16(adc_chb), sext16(adc_cha)}`.
- `out_valid`  out  1  `out_data` is held for the stream master.
- `out_ready`  in  1  the stream master accepts the beat in this cycle.
- `out_last`  out  1  qualifies `out_data`; marks the final sample of a frame.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when a finite run completes.
- `overflow`  out  1  sticky; a kept sample was dropped.
- `frame_cnt`  out  CNT_W  frames completed in the current run.

## Operation
- Config latched on the accepted `cfg_start`. Changing the config inputs mid-run has no effect.
- States:
  - IDLE: on `cfg_start` with `cfg_frame_len`≠0:
    - clear sample, decimation and frame counters;
    - clear `overflow`;
    - go to ARMED if `cfg_trig_en`, else CAPTURE.
  - ARMED: go to CAPTURE on `trig_in`=1 while the registered previous `trig_in`=0.
    - Clear the decimation counter on that transition.
    - Ignore `adc_valid` while in ARMED.
  - CAPTURE: process each `adc_valid` through the decimator. At the end of a frame (kept sample with sample_cnt = frame_len−1):
    - clear sample_cnt and increment `frame_cnt`;
    - go to DRAIN if `cfg_num_frames`≠0 and the new `frame_cnt` = `cfg_num_frames`;
    - else go to ARMED if trig_en;
    - else stay in CAPTURE.
  - DRAIN: go to IDLE when `out_valid`=0, or in the cycle its final beat is accepted. `done` pulses on entry to IDLE.
- Decimation:
  - The counter advances only on `adc_valid` in CAPTURE.
  - A sample is kept when the count is 0.
  - The count wraps from `cfg_decim` to 0. `cfg_decim`=0 keeps every sample.
- Output register, single entry. A kept sample loads `out_data`/`out_last` and sets `out_valid`, provided `out_valid`=0 or `out_ready`=1 in that cycle.
- A kept sample arriving while `out_valid`=1 and `out_ready`=0:
  - the sample is dropped and `overflow` is set;
  - sample_cnt does not advance, so frames always contain `cfg_frame_len` delivered beats.
- `out_valid` clears on handshake when no new kept sample arrives.
- `cfg_abort` has priority over everything:
  - next state IDLE, `out_valid`←0, no `done`;
  - `frame_cnt` and `overflow` hold their values.
- `cfg_start` and `cfg_abort` in the same cycle: abort wins.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `done`=0, `overflow`=0, `frame_cnt`=0; state IDLE.
- `cfg_start` at cycle N → state and `busy` change at N+1.
- Kept `adc_valid` at cycle N → `out_valid`=1 with its data at N+1.
- Trigger edge at cycle N → CAPTURE at N+1. A sample at N+1 is eligible.
- Final-beat handshake at cycle N in DRAIN → IDLE and `done`=1 at N+1; `busy`=0 at N+1.
- Back-to-back `adc_valid` with `out_ready` held high → one beat per cycle, no loss.
- `ARESET` mid-run → all outputs at reset values on the next cycle.

## Test plan
- Start with frame_len=4, num_frames=2, decim=0, trig_en=0, out_ready=1, adc_valid every 2 cycles, cha=0x1FFF, chb=0x2000:
  - 8 beats with out_data=0xE000_1FFF;
  - out_last on beats 4 and 8;
  - frame_cnt=2;
  - done pulse 1 cycle after beat 8.
- decim=2, frame_len=3, 9 consecutive adc_valid → beats carry samples 0, 3, 6 only, with out_last on the third beat.
- trig_en=1: samples before the trigger edge produce no beats. Each frame requires a new rising edge; a held-high trig_in does not re-trigger.
- out_ready=0 for 3 kept samples with frame_len=4:
  - the first sample is held and the next two are dropped;
  - overflow=1;
  - after out_ready returns, the frame still ends on the 4th delivered beat.
- Abort during CAPTURE with out_valid=1 → IDLE next cycle, out_valid=0, no done pulse. A subsequent start clears overflow.
- ARESET asserted mid-frame, then start with frame_len=0 → all outputs at reset values and start ignored (busy stays 0).
